regchange_serializer: RTL

- Consumer end of the register-change detection path in the RVVI trace logic.
- Takes the per-register Change flags and current values from a bank of change detectors, and snapshots them on a Capture strobe (one per retired instruction / trace slot).
- Pulses the detectors' clear inputs for every captured register.
- Serialises the changed registers as (index, value) records over a valid/ready stream, lowest index first, towards the RVVI packet builder.

---
 rtl/regchange_serializer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/regchange_serializer.sv
// Snapshots register Change flags/values on Capture and streams changed registers as
// (index, value) records, lowest index first. Optional counters: REGCHANGE_SERIALIZER_COUNT_EN.
module regchange_serializer #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned IDXW    = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     Capture,
  input  logic [NUM_REGS-1:0]      ChangeVec,
  input  logic [NUM_REGS*XLEN-1:0] ValueVec,
  output logic [NUM_REGS-1:0]      Clear,
  output logic                     Busy,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [IDXW-1:0]          OutIndex,
  output logic [XLEN-1:0]          OutValue,
  output logic                     OutLast,
  output logic                     Done,
`ifdef REGCHANGE_SERIALIZER_COUNT_EN
  output logic [15:0]              RecordCount,
  output logic [15:0]              SnapCount,
`endif
  output logic                     Overrun
);

  typedef enum logic [1:0] {StIdle, StSend, StDone} state_e;

  state_e                r_state, w_state_next;
  logic [NUM_REGS-1:0]   r_pending;
  logic [NUM_REGS-1:0]   r_clear;
  logic                  r_overrun;
  logic [XLEN-1:0]       r_snap [NUM_REGS];

  logic [IDXW-1:0]       w_idx;
  logic [NUM_REGS-1:0]   w_lowbit;
  logic                  w_last;
  logic                  w_accept;
  logic                  w_hshake;

  // Priority encoder: descending scan leaves the lowest set bit.
  always_comb begin
    w_idx    = '0;
    w_lowbit = '0;
    for (int i = NUM_REGS - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_idx       = IDXW'(i);
        w_lowbit    = '0;
        w_lowbit[i] = 1'b1;
      end
    end
  end

  assign w_last   = (r_pending != '0) && ((r_pending & ~w_lowbit) == '0);
  assign w_accept = Capture && (r_state == StIdle);
  assign w_hshake = (r_state == StSend) && OutReady;

  always_comb begin
    w_state_next = r_state;
    Busy         = 1'b1;
    OutValid     = 1'b0;
    OutIndex     = '0;
    OutValue     = '0;
    OutLast      = 1'b0;
    Done         = 1'b0;
    unique case (r_state)
      StIdle: begin
        Busy = 1'b0;
        if (Capture) w_state_next = (ChangeVec != '0) ? StSend : StDone;
      end
      StSend: begin
        OutValid = 1'b1;
        OutIndex = w_idx;
        OutValue = r_snap[w_idx];
        OutLast  = w_last;
        if (OutReady && w_last) w_state_next = StDone;
      end
      StDone: begin
        Done         = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_pending <= '0;
      r_clear   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_clear <= w_accept ? ChangeVec : '0;
      if (w_accept) begin
        r_pending <= ChangeVec;
      end else if (w_hshake) begin
        r_pending <= r_pending & ~w_lowbit;
      end
      if (Capture && (r_state != StIdle)) r_overrun <= 1'b1;
    end
  end

  // Snapshot storage is deliberately left unreset; it is only read behind r_pending.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_snap[i] <= ValueVec[i*XLEN +: XLEN];
      end
    end
  end

  assign Clear   = r_clear;
  assign Overrun = r_overrun;

`ifdef REGCHANGE_SERIALIZER_COUNT_EN
  logic [15:0] r_record_count;
  logic [15:0] r_snap_count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_record_count <= '0;
      r_snap_count   <= '0;
    end else begin
      if (w_hshake && (r_record_count != 16'hFFFF)) r_record_count <= r_record_count + 16'd1;
      if (w_accept && (r_snap_count != 16'hFFFF))   r_snap_count   <= r_snap_count + 16'd1;
    end
  end

  assign RecordCount = r_record_count;
  assign SnapCount   = r_snap_count;
`endif

endmodule
